// File: rtl/signed_mult_sequencer_if.sv
// Handshake bundle for the signed multiply sequencer: operand side (in_*, a, b)
// and product side (out_*, product), plus the busy status flag.
interface signed_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/signed_mult_sequencer.sv
// Signed multiply sequencer: sign-magnitude split, WIDTH-cycle shift-add
// multiply, then sign fix-up, with valid/ready handshakes on both sides.
module signed_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  signed_mult_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    MUL,
    FIX,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 busy_reg;
  logic [WIDTH:0]       sum;

  // Partial-product add into the upper half; the carry becomes the new MSB after the shift.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      mag_a         <= '0;
      mag_b         <= '0;
      neg           <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= ABS;
          end
        end
        ABS: begin
          mag_a <= a_reg[WIDTH-1] ? (~a_reg + ONE_W) : a_reg;
          mag_b <= b_reg[WIDTH-1] ? (~b_reg + ONE_W) : b_reg;
          neg   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          acc   <= '0;
          cnt   <= '0;
          state <= MUL;
        end
        MUL: begin
          acc   <= {sum, acc[WIDTH-1:1]};
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CNT_ONE;
          if (cnt == CNT_END) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero magnitude with neg set wraps back to zero here.
          product_reg   <= neg ? (~acc + ONE_P) : acc;
          out_valid_reg <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;
  assign bus.busy      = busy_reg;
endmodule
